// File: rtl/rs5_wb_data_bridge.sv
// rs5_wb_data_bridge: single-outstanding bridge from the RS5 core data port to a
// pipelined Wishbone master. One transaction at a time: IDLE -> REQ -> WAIT_ACK -> DONE.
// Optional feature: define BRIDGE_TIMEOUT_EN to bound the wait for wb_ack_i to
// TIMEOUT_CYCLES cycles; a timed-out transaction completes with core_err_o=1 and,
// for reads, core_rdata_o=ERR_RDATA. Without the macro the bridge waits forever.
module rs5_wb_data_bridge #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst_n,

    input  logic        core_req_i,
    input  logic [3:0]  core_we_i,
    input  logic [31:0] core_addr_i,
    input  logic [31:0] core_wdata_i,
    output logic        core_stall_o,
    output logic [31:0] core_rdata_o,
    output logic        core_rvalid_o,
    output logic        core_err_o,

    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_stall_i
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT_ACK,
        DONE
    } state_t;

    state_t      state_q,  state_d;
    logic        cyc_q,    cyc_d;
    logic        stb_q,    stb_d;
    logic        we_q,     we_d;
    logic [3:0]  sel_q,    sel_d;
    logic [31:0] adr_q,    adr_d;
    logic [31:0] dat_q,    dat_d;
    logic [31:0] rdata_q,  rdata_d;
    logic        rvalid_q, rvalid_d;

    logic        busy;      // a Wishbone cycle is open (REQ or WAIT_ACK)
    logic        ack_done;  // the slave completes the transaction this cycle
    logic        tmo;       // the wait budget runs out this cycle

    assign busy = (state_q == REQ) || (state_q == WAIT_ACK);

    // An ack only counts once the strobe has been accepted (stall low) or while waiting for it
    always_comb begin
        ack_done = 1'b0;
        if (state_q == REQ) begin
            ack_done = wb_ack_i && !wb_stall_i;
        end else if (state_q == WAIT_ACK) begin
            ack_done = wb_ack_i;
        end
    end

`ifdef BRIDGE_TIMEOUT_EN
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    // cnt_q holds the number of earlier busy cycles; this cycle is number cnt_q+1
    always_comb begin
        tmo = busy && (({{(32-CNT_W){1'b0}}, cnt_q} + 32'd1) >= TIMEOUT_CYCLES);
    end

    assign core_err_o = err_q;
`else
    assign tmo        = 1'b0;
    assign core_err_o = 1'b0;
`endif

    // Next-state, next-output and core stall decode
    always_comb begin
        state_d      = state_q;
        cyc_d        = cyc_q;
        stb_d        = stb_q;
        we_d         = we_q;
        sel_d        = sel_q;
        adr_d        = adr_q;
        dat_d        = dat_q;
        rdata_d      = rdata_q;
        rvalid_d     = 1'b0;
        core_stall_o = 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
        cnt_d        = '0;
        err_d        = 1'b0;
`endif

        case (state_q)
            IDLE: begin
                if (core_req_i) begin
                    core_stall_o = 1'b1;
                    state_d      = REQ;
                    cyc_d        = 1'b1;
                    stb_d        = 1'b1;
                    we_d         = |core_we_i;
                    sel_d        = (|core_we_i) ? core_we_i : 4'hF;
                    adr_d        = {core_addr_i[31:2], 2'b00};
                    dat_d        = core_wdata_i;
                end
            end

            REQ, WAIT_ACK: begin
                core_stall_o = 1'b1;
                if (ack_done || tmo) begin
                    // Ack wins over a simultaneous timeout; both close the cycle the same way
                    state_d  = DONE;
                    cyc_d    = 1'b0;
                    stb_d    = 1'b0;
                    rvalid_d = 1'b1;
                    if (!we_q) begin
                        rdata_d = ack_done ? wb_dat_i : ERR_RDATA;
                    end
`ifdef BRIDGE_TIMEOUT_EN
                    err_d = !ack_done;
`endif
                end else begin
                    if ((state_q == REQ) && !wb_stall_i) begin
                        state_d = WAIT_ACK;
                        stb_d   = 1'b0;
                    end
`ifdef BRIDGE_TIMEOUT_EN
                    cnt_d = cnt_q + CNT_ONE;
`endif
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
            end
        endcase
    end

    // State and registered outputs, cleared asynchronously by rst_n
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cyc_q    <= 1'b0;
            stb_q    <= 1'b0;
            we_q     <= 1'b0;
            sel_q    <= '0;
            adr_q    <= '0;
            dat_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
`ifdef BRIDGE_TIMEOUT_EN
            cnt_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cyc_q    <= cyc_d;
            stb_q    <= stb_d;
            we_q     <= we_d;
            sel_q    <= sel_d;
            adr_q    <= adr_d;
            dat_q    <= dat_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
`ifdef BRIDGE_TIMEOUT_EN
            cnt_q    <= cnt_d;
            err_q    <= err_d;
`endif
        end
    end

    assign wb_cyc_o      = cyc_q;
    assign wb_stb_o      = stb_q;
    assign wb_we_o       = we_q;
    assign wb_sel_o      = sel_q;
    assign wb_adr_o      = adr_q;
    assign wb_dat_o      = dat_q;
    assign core_rdata_o  = rdata_q;
    assign core_rvalid_o = rvalid_q;

endmodule

// File: tb/tb_rs5_wb_data_bridge.sv
// Bench for rs5_wb_data_bridge: directed and random transactions; completions
// are checked by a monitor against a queue of expected {rdata, err, cycle}.
`timescale 1ns/1ps
module tb_rs5_wb_data_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        core_req_i = 1'b0;
    logic [3:0]  core_we_i = '0;
    logic [31:0] core_addr_i = '0;
    logic [31:0] core_wdata_i = '0;
    logic        core_stall_o;
    logic [31:0] core_rdata_o;
    logic        core_rvalid_o;
    logic        core_err_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
    logic        wb_stall_i = 1'b0;

    always #5 clk = ~clk;

    rs5_wb_data_bridge #(
        .TIMEOUT_CYCLES(8),
        .ERR_RDATA(32'hDEADBEEF)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .core_req_i(core_req_i),
        .core_we_i(core_we_i),
        .core_addr_i(core_addr_i),
        .core_wdata_i(core_wdata_i),
        .core_stall_o(core_stall_o),
        .core_rdata_o(core_rdata_o),
        .core_rvalid_o(core_rvalid_o),
        .core_err_o(core_err_o),
        .wb_cyc_o(wb_cyc_o),
        .wb_stb_o(wb_stb_o),
        .wb_we_o(wb_we_o),
        .wb_sel_o(wb_sel_o),
        .wb_adr_o(wb_adr_o),
        .wb_dat_o(wb_dat_o),
        .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i),
        .wb_stall_i(wb_stall_i)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned cycle;
    } exp_t;

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int unsigned cyc_cnt = 0;
    logic [31:0] last_read = '0;   // model of the word core_rdata_o must hold

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc_cnt);
    endtask

    // Monitor: every completion pulse pops one expectation
    always @(negedge clk) begin
        exp_t e;
        if (core_rvalid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_rvalid: got rvalid=1 at cycle %0d, required no completion", cyc_cnt);
            end else begin
                e = exp_q.pop_front();
                chk("rdata", core_rdata_o, e.rdata);
                chk("err", {31'b0, core_err_o}, {31'b0, e.err});
                chk("rvalid_cycle", cyc_cnt, e.cycle);
            end
        end
    end

    // One transaction: s stall cycles on the strobe, ack a cycles after strobe acceptance
    task automatic do_txn(input logic [3:0] we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rd, input int unsigned s, input int unsigned a);
        exp_t        e;
        logic [3:0]  sel_exp;
        int unsigned c0;
        sel_exp = (we == 4'h0) ? 4'hF : we;
        core_req_i   = 1'b1;
        core_we_i    = we;
        core_addr_i  = addr;
        core_wdata_i = wdata;
        @(negedge clk);
        chk("stall_on_accept", {31'b0, core_stall_o}, 32'd1);
        c0 = cyc_cnt;
        if (we == 4'h0) last_read = rd;
        e.rdata = last_read;
        e.err   = 1'b0;
        e.cycle = c0 + 2 + s + a;
        exp_q.push_back(e);
        @(posedge clk); #1;
        core_req_i   = 1'b0;
        core_we_i    = 4'($urandom);
        core_addr_i  = $urandom;
        core_wdata_i = $urandom;
        for (int unsigned i = 0; i <= s; i++) begin
            wb_stall_i = (i < s);
            wb_ack_i   = (i == s) && (a == 0);
            wb_dat_i   = ((i == s) && (a == 0)) ? rd : $urandom;
            @(negedge clk);
            chk("stb_req", {31'b0, wb_stb_o}, 32'd1);
            chk("cyc_req", {31'b0, wb_cyc_o}, 32'd1);
            chk("adr", wb_adr_o, {addr[31:2], 2'b00});
            chk("sel", {28'b0, wb_sel_o}, {28'b0, sel_exp});
            chk("we", {31'b0, wb_we_o}, {31'b0, (we != 4'h0)});
            chk("dat_o", wb_dat_o, wdata);
            chk("stall_req", {31'b0, core_stall_o}, 32'd1);
            @(posedge clk); #1;
        end
        wb_stall_i = 1'b0;
        wb_ack_i   = 1'b0;
        for (int unsigned j = 1; j <= a; j++) begin
            wb_ack_i = (j == a);
            wb_dat_i = (j == a) ? rd : $urandom;
            @(negedge clk);
            chk("cyc_wait", {31'b0, wb_cyc_o}, 32'd1);
            chk("stb_wait", {31'b0, wb_stb_o}, 32'd0);
            chk("stall_wait", {31'b0, core_stall_o}, 32'd1);
            @(posedge clk); #1;
        end
        // Completion cycle: a stray ack here must change nothing
        wb_ack_i = 1'($urandom_range(0, 1));
        wb_dat_i = $urandom;
        @(negedge clk);
        chk("cyc_done", {31'b0, wb_cyc_o}, 32'd0);
        chk("stall_done", {31'b0, core_stall_o}, 32'd0);
        @(posedge clk); #1;
        wb_ack_i = 1'b0;
    endtask

    // Idle cycles with stray acks and noise on the core inputs
    task automatic idle(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            core_req_i   = 1'b0;
            core_we_i    = 4'($urandom);
            core_addr_i  = $urandom;
            wb_ack_i     = 1'($urandom_range(0, 1));
            wb_dat_i     = $urandom;
            @(negedge clk);
            chk("cyc_idle", {31'b0, wb_cyc_o}, 32'd0);
            chk("stall_idle", {31'b0, core_stall_o}, 32'd0);
            chk("rdata_hold", core_rdata_o, last_read);
            @(posedge clk); #1;
        end
        wb_ack_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

    initial begin
        exp_t        e;
        int unsigned c0;
        logic [31:0] d1, d2, a1, a2;

        // Reset values
        @(negedge clk);
        chk("rst_cyc", {31'b0, wb_cyc_o}, 32'd0);
        chk("rst_stb", {31'b0, wb_stb_o}, 32'd0);
        chk("rst_we", {31'b0, wb_we_o}, 32'd0);
        chk("rst_sel", {28'b0, wb_sel_o}, 32'd0);
        chk("rst_adr", wb_adr_o, 32'd0);
        chk("rst_dat", wb_dat_o, 32'd0);
        chk("rst_rdata", core_rdata_o, 32'd0);
        chk("rst_rvalid", {31'b0, core_rvalid_o}, 32'd0);
        chk("rst_err", {31'b0, core_err_o}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(2);

        // Read, no stall, ack one cycle after strobe
        do_txn(4'h0, 32'h0000_1006, 32'h0, 32'h1234_5678, 0, 1);
        idle(1);
        // Halfword write held off by three stall cycles
        do_txn(4'b0011, 32'h0000_0020, 32'hAABB_CCDD, $urandom, 3, 1);
        idle(1);
        // Ack in the same cycle the stall drops
        do_txn(4'h0, $urandom, $urandom, $urandom, 2, 0);
        idle(1);

        // Back-to-back reads with the request held high
        d1 = $urandom; d2 = $urandom; a1 = $urandom; a2 = $urandom;
        core_req_i = 1'b1; core_we_i = 4'h0; core_addr_i = a1;
        @(negedge clk);
        chk("b2b_stall1", {31'b0, core_stall_o}, 32'd1);
        c0 = cyc_cnt;
        last_read = d1;
        e.rdata = d1; e.err = 1'b0; e.cycle = c0 + 2;
        exp_q.push_back(e);
        @(posedge clk); #1;
        wb_stall_i = 1'b0; wb_ack_i = 1'b1; wb_dat_i = d1;
        @(negedge clk);
        chk("b2b_stb1", {31'b0, wb_stb_o}, 32'd1);
        chk("b2b_adr1", wb_adr_o, {a1[31:2], 2'b00});
        @(posedge clk); #1;
        wb_ack_i = 1'b0; core_addr_i = a2;
        @(negedge clk);
        chk("b2b_stall_done", {31'b0, core_stall_o}, 32'd0);
        chk("b2b_cyc_done", {31'b0, wb_cyc_o}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("b2b_stall2", {31'b0, core_stall_o}, 32'd1);
        chk("b2b_no_early_stb", {31'b0, wb_stb_o}, 32'd0);
        last_read = d2;
        e.rdata = d2; e.err = 1'b0; e.cycle = c0 + 5;
        exp_q.push_back(e);
        @(posedge clk); #1;
        core_req_i = 1'b0; wb_ack_i = 1'b1; wb_dat_i = d2;
        @(negedge clk);
        chk("b2b_stb2", {31'b0, wb_stb_o}, 32'd1);
        chk("b2b_adr2", wb_adr_o, {a2[31:2], 2'b00});
        @(posedge clk); #1;
        wb_ack_i = 1'b0;
        idle(2);

        // Random traffic
        for (int unsigned t = 0; t < 40; t++) begin
            do_txn(($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0, $urandom, $urandom, $urandom,
                   $urandom_range(0, 3), $urandom_range(0, 3));
            idle($urandom_range(0, 2));
        end

        // Reset during WAIT_ACK abandons the transaction; late ack ignored
        core_req_i = 1'b1; core_we_i = 4'h0; core_addr_i = $urandom;
        @(negedge clk);
        @(posedge clk); #1;
        core_req_i = 1'b0; wb_stall_i = 1'b0; wb_ack_i = 1'b0;
        @(negedge clk);
        @(posedge clk); #1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_cyc", {31'b0, wb_cyc_o}, 32'd0);
        chk("arst_stb", {31'b0, wb_stb_o}, 32'd0);
        chk("arst_adr", wb_adr_o, 32'd0);
        chk("arst_sel", {28'b0, wb_sel_o}, 32'd0);
        chk("arst_rdata", core_rdata_o, 32'd0);
        last_read = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        wb_ack_i = 1'b1; wb_dat_i = $urandom;
        @(negedge clk);
        chk("late_ack_cyc", {31'b0, wb_cyc_o}, 32'd0);
        chk("late_ack_rvalid", {31'b0, core_rvalid_o}, 32'd0);
        @(posedge clk); #1;
        wb_ack_i = 1'b0;
        @(negedge clk);
        chk("late_ack_rvalid2", {31'b0, core_rvalid_o}, 32'd0);
        chk("late_ack_rdata", core_rdata_o, 32'd0);
        @(posedge clk); #1;
        idle(1);

`ifdef BRIDGE_TIMEOUT_EN
        // Read that is never acked times out after 8 busy cycles
        core_req_i = 1'b1; core_we_i = 4'h0; core_addr_i = $urandom;
        @(negedge clk);
        c0 = cyc_cnt;
        last_read = 32'hDEADBEEF;
        e.rdata = 32'hDEADBEEF; e.err = 1'b1; e.cycle = c0 + 9;
        exp_q.push_back(e);
        @(posedge clk); #1;
        core_req_i = 1'b0; wb_stall_i = 1'b0; wb_ack_i = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("tmo_cyc_busy", {31'b0, wb_cyc_o}, 32'd1);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("tmo_cyc_done", {31'b0, wb_cyc_o}, 32'd0);
        @(posedge clk); #1;
        idle(2);
`else
        // Without the timeout the bridge keeps waiting for the ack
        do_txn(4'h0, $urandom, $urandom, $urandom, 0, 40);
        idle(2);
`endif

        chk("pending_expectations", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/rs5_wb_data_bridge.md
RS5_WB_DATA_BRIDGE -- requirements
Module: rs5_wb_data_bridge

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, meaning the maximum number of cycles spent waiting for wb_ack_i per transaction.
REQ-002 SHALL have parameter ERR_RDATA, default 32'hDEADBEEF, meaning the read data returned on a timed-out transaction.
REQ-003 SHALL have ports: clk in 1 (single clock); rst_n in 1 (reset, asynchronous, active-low).
REQ-004 SHALL have core-side ports: core_req_i in 1 (memory operation enable); core_we_i in 4 (byte write enables, 0 = read); core_addr_i in 32; core_wdata_i in 32; core_stall_o out 1; core_rdata_o out 32; core_rvalid_o out 1 (one-cycle completion pulse); core_err_o out 1.
REQ-005 SHALL have pipelined Wishbone master ports: wb_cyc_o out 1; wb_stb_o out 1; wb_we_o out 1; wb_sel_o out 4; wb_adr_o out 32; wb_dat_o out 32; wb_dat_i in 32; wb_ack_i in 1; wb_stall_i in 1.

Function
REQ-006 SHALL implement FSM states IDLE, REQ, WAIT_ACK, DONE.
REQ-007 IDLE with core_req_i=1: SHALL latch addr/we/wdata and go to REQ next cycle; SHALL assert core_stall_o combinationally in that same cycle.
REQ-008 SHALL assert core_stall_o in REQ and WAIT_ACK, and deassert it in IDLE (no request) and DONE.
REQ-009 REQ: wb_cyc_o=1, wb_stb_o=1, registered fields driven; stays in REQ while wb_stall_i=1; on wb_stall_i=0 goes to WAIT_ACK (or directly to DONE if wb_ack_i=1 in the same cycle).
REQ-010 WAIT_ACK: wb_cyc_o=1, wb_stb_o=0; on wb_ack_i=1 SHALL capture wb_dat_i and go to DONE.
REQ-011 DONE: lasts exactly one cycle; core_rvalid_o=1; wb_cyc_o=0; returns to IDLE.
REQ-012 wb_adr_o SHALL be {addr[31:2],2'b00}; wb_we_o = (we != 0); wb_sel_o = we for writes, 4'b1111 for reads; wb_dat_o = latched wdata.
REQ-013 core_rdata_o SHALL hold the last captured read word until the next completion; for writes it is left unchanged.
REQ-014 Minimum latency: request in cycle 0, stb in cycle 1, ack earliest cycle 1 or 2, core_rvalid_o in cycle 2 or 3.
REQ-015 wb_ack_i while in IDLE or DONE SHALL be ignored (no state or data change).
REQ-016 core_req_i while not in IDLE SHALL be ignored; core holds the request under stall.
REQ-017 Back-to-back: a request presented in the DONE cycle SHALL NOT be accepted; it is accepted in the following IDLE cycle.

Reset
REQ-018 rst_n low SHALL immediately, asynchronously force state IDLE, wb_cyc_o=0, wb_stb_o=0, wb_we_o=0, wb_sel_o=0, wb_adr_o=0, wb_dat_o=0, core_rdata_o=0, core_rvalid_o=0, core_err_o=0, timeout counter=0.
REQ-019 Reset asserted mid-transaction SHALL abandon the transaction with no completion pulse; a late ack after reset release SHALL be ignored.

Configuration
REQ-020 Macro BRIDGE_TIMEOUT_EN defined: counter SHALL count cycles in REQ+WAIT_ACK; upon reaching TIMEOUT_CYCLES without ack, SHALL go to DONE with core_rdata_o=ERR_RDATA (reads only), core_err_o=1 for that one cycle, wb_cyc_o dropped.
REQ-021 Macro undefined: no counter logic; SHALL wait indefinitely for ack; core_err_o tied 0.

Verification
REQ-022 Read at 0x00001006, wb_stall_i=0, ack 1 cycle after stb, wb_dat_i=0x12345678 -> wb_adr_o=0x00001004, wb_sel_o=4'hF, wb_we_o=0, core_rvalid_o in cycle 3, core_rdata_o=0x12345678.
REQ-023 Write we=4'b0011, addr 0x20, wdata 0xAABBCCDD, wb_stall_i high 3 cycles -> stb held 4 cycles, wb_sel_o=4'b0011, wb_we_o=1, single rvalid pulse after ack.
REQ-024 Ack in same cycle as stall drop -> direct REQ->DONE, rvalid next cycle, no WAIT_ACK cycle.
REQ-025 rst_n pulsed low during WAIT_ACK -> wb_cyc_o=0 same cycle, no rvalid; ack after release ignored, outputs at reset values.
REQ-026 BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES=8, read never acked -> rvalid and core_err_o high together, core_rdata_o=0xDEADBEEF, wb_cyc_o low; without macro, stall persists indefinitely.
REQ-027 Two reads back-to-back with core_req_i held high -> second stb issued exactly two cycles after first DONE-cycle rvalid... i.e. IDLE acceptance one cycle after DONE, stb the cycle after.
